// File: rtl/proc_pkg.sv
// Shared encodings for the processor control unit: bus-select codes,
// opcodes and the FSM state type.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  // Bus mux select codes
  localparam logic [3:0] SEL_R0 = 4'd0;
  localparam logic [3:0] SEL_R1 = 4'd1;
  localparam logic [3:0] SEL_R2 = 4'd2;
  localparam logic [3:0] SEL_R3 = 4'd3;
  localparam logic [3:0] SEL_R4 = 4'd4;
  localparam logic [3:0] SEL_R5 = 4'd5;
  localparam logic [3:0] SEL_R6 = 4'd6;
  localparam logic [3:0] SEL_R7 = 4'd7;
  localparam logic [3:0] SEL_G  = 4'd8;
  localparam logic [3:0] SEL_D  = 4'd9;
  localparam logic [3:0] SEL_DT = 4'd10;

  // Opcodes (ir[15:12]); everything from 7 upwards is undefined
  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_MVI  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MVT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_SUBI = 4'd6;

  // Register-number to bus-select code; R0..R7 occupy codes 0..7
  function automatic logic [3:0] sel_reg(input logic [2:0] r);
    return {1'b0, r};
  endfunction

  // True for the opcodes that take the three-step ALU path
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
  endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// 3-to-8 one-hot decoder with enable, used for the register write strobes.
module dec3to8 (
  input  logic [2:0] w,
  input  logic       en,
  output logic [7:0] y
);

  // One output bit per register; only the addressed bit fires when enabled
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dec
      assign y[gi] = en && (w == 3'(gi));
    end
  endgenerate

endmodule

// File: rtl/proc_control.sv
// Control FSM for a simple multi-cycle processor: decodes ir and sequences
// the bus select, register/ALU enables and the completed-instruction count.
module proc_control
  import proc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [15:0] ir,
  output logic        ir_in,
  output logic [3:0]  sel,
  output logic [7:0]  r_in,
  output logic        a_in,
  output logic        g_in,
  output logic        addsub,
  output logic        done,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] instr_cnt
);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] cnt_reg;
  logic        rin_en;

  logic [3:0] opcode;
  logic [2:0] rx;
  logic [2:0] ry;

  assign opcode = ir[15:12];
  assign rx     = ir[11:9];
  assign ry     = ir[2:0];

  // Immediate bits feed the datapath directly, not this controller
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir[8:3];

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= T0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: moves and illegal opcodes finish in T1, ALU ops in T3
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      T0:      state_next = run ? T1 : T0;
      T1:      state_next = is_alu_op(opcode) ? T2 : T0;
      T2:      state_next = T3;
      T3:      state_next = T0;
      default: state_next = T0;
    endcase
  end

  // Output decode from current state and instruction fields
  always_comb begin
    ir_in   = 1'b0;
    sel     = SEL_R0;
    rin_en  = 1'b0;
    a_in    = 1'b0;
    g_in    = 1'b0;
    addsub  = 1'b0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_reg)
      T0: begin
        ir_in = run;
      end
      T1: begin
        case (opcode)
          OP_MV: begin
            sel    = sel_reg(ry);
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_MVI: begin
            sel    = SEL_D;
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_MVT: begin
            sel    = SEL_DT;
            rin_en = 1'b1;
            done   = 1'b1;
          end
          OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
            sel  = sel_reg(rx);
            a_in = 1'b1;
          end
          default: begin
            done    = 1'b1;
            illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        sel    = ((opcode == OP_ADDI) || (opcode == OP_SUBI)) ? SEL_D : sel_reg(ry);
        g_in   = 1'b1;
        addsub = (opcode == OP_SUB) || (opcode == OP_SUBI);
      end
      T3: begin
        sel    = SEL_G;
        rin_en = 1'b1;
        done   = 1'b1;
      end
      default: begin
        sel = SEL_R0;
      end
    endcase
  end

  // Register write strobes always target rX
  dec3to8 u_dec (
    .w  (rx),
    .en (rin_en),
    .y  (r_in)
  );

  assign busy = (state_reg != T0);

  // Completed-instruction counter; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 16'h0000;
    end else if (done) begin
      cnt_reg <= cnt_reg + 16'h0001;
    end
  end

  assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: the stimulus process queues the
// expected output vector for every active cycle, the monitor checks it.
module tb_proc_control;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] ir;
  logic        ir_in;
  logic [3:0]  sel;
  logic [7:0]  r_in;
  logic        a_in;
  logic        g_in;
  logic        addsub;
  logic        done;
  logic        busy;
  logic        illegal;
  logic [15:0] instr_cnt;

  typedef struct packed {
    logic        ir_in;
    logic [3:0]  sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic        addsub;
    logic        done;
    logic        busy;
    logic        illegal;
    logic [15:0] cnt;
  } vec_t;

  vec_t exp_q[$];
  int   tests;
  int   fails;
  logic [15:0] exp_cnt;
  bit   mon_en;

  proc_control dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .ir        (ir),
    .ir_in     (ir_in),
    .sel       (sel),
    .r_in      (r_in),
    .a_in      (a_in),
    .g_in      (g_in),
    .addsub    (addsub),
    .done      (done),
    .busy      (busy),
    .illegal   (illegal),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t actual();
    vec_t v;
    v = '{ir_in: ir_in, sel: sel, r_in: r_in, a_in: a_in, g_in: g_in,
          addsub: addsub, done: done, busy: busy, illegal: illegal, cnt: instr_cnt};
    return v;
  endfunction

  function automatic string fmt(input vec_t v);
    return $sformatf("ir_in=%0b sel=%0d r_in=%02h a=%0b g=%0b as=%0b done=%0b busy=%0b ill=%0b cnt=%04h",
                     v.ir_in, v.sel, v.r_in, v.a_in, v.g_in, v.addsub, v.done, v.busy, v.illegal, v.cnt);
  endfunction

  // Monitor: whenever the controller is active, pop and compare
  always @(negedge clk) begin
    if (mon_en && (ir_in || busy)) begin
      vec_t a;
      vec_t e;
      a = actual();
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_activity: got %s required no activity", fmt(a));
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL cycle_outputs: got %s required %s", fmt(a), fmt(e));
        end else begin
          $display("[TB] ok %s", fmt(a));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic iri, input logic [3:0] s, input logic [7:0] r,
                      input logic a, input logic g, input logic as_op,
                      input logic dn, input logic bz, input logic ill);
    vec_t v;
    v = '{ir_in: iri, sel: s, r_in: r, a_in: a, g_in: g, addsub: as_op,
          done: dn, busy: bz, illegal: ill, cnt: exp_cnt};
    exp_q.push_back(v);
    if (dn) exp_cnt = exp_cnt + 16'h0001;
  endtask

  // T0 cycle with run asserted; optionally keep run high afterwards
  task automatic start(input logic [15:0] instr, input bit hold);
    ir  = instr;
    run = 1'b1;
    push(1'b1, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    if (!hold) run = 1'b0;
  endtask

  task automatic cyc(input logic [3:0] s, input logic [7:0] r, input logic a,
                     input logic g, input logic as_op, input logic dn, input logic ill);
    push(1'b0, s, r, a, g, as_op, dn, 1'b1, ill);
    step();
  endtask

  task automatic check16(input string name, input logic [15:0] got, input logic [15:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %04h required %04h", name, got, req);
    end else begin
      $display("[TB] ok %s = %04h", name, got);
    end
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    exp_cnt = 16'h0000;
    mon_en  = 1'b0;
    rst     = 1'b1;
    run     = 1'b0;
    ir      = 16'h0000;
    step();
    step();
    rst    = 1'b0;
    mon_en = 1'b1;

    // Idle after reset: every output zero
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (actual() !== vec_t'(0)) begin
        fails++;
        $display("FAIL idle_after_reset: got %s required all zero", fmt(actual()));
      end else begin
        $display("[TB] ok idle cycle %0d", i);
      end
    end

    // sub R1,R2 aborted by reset in T2: no done, no count
    start(16'h3202, 1'b0);
    cyc(4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check16("abort_busy", {15'd0, busy}, 16'h0000);
    check16("abort_done", {15'd0, done}, 16'h0000);
    check16("abort_cnt", instr_cnt, 16'h0000);

    // mvi R1,#5
    start(16'h1205, 1'b0);
    cyc(4'd9, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check16("cnt_after_mvi", instr_cnt, 16'h0001);

    // add R3,R2
    start(16'h2602, 1'b0);
    cyc(4'd3, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'd2, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4'd8, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // subi R5,#7
    start(16'h6A07, 1'b0);
    cyc(4'd5, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'd9, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'd8, 8'h20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // mvt R6,#0xAB
    start(16'h4CAB, 1'b0);
    cyc(4'd10, 8'h40, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // mv R7,R7 (rX = rY)
    start(16'h0E07, 1'b0);
    cyc(4'd7, 8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // sub R1,R2 to completion
    start(16'h3202, 1'b0);
    cyc(4'd1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(4'd2, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(4'd8, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Three illegal 0xF000 with run held high: back-to-back
    start(16'hF000, 1'b1);
    cyc(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    start(16'hF000, 1'b1);
    cyc(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    start(16'hF000, 1'b0);
    cyc(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Lowest undefined opcode
    start(16'h7000, 1'b0);
    cyc(4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check16("cnt_after_sequence", instr_cnt, 16'd10);

    // Counter wrap: preload 0xFFFF, then one instruction
    force dut.cnt_reg = 16'hFFFF;
    step();
    release dut.cnt_reg;
    exp_cnt = 16'hFFFF;
    check16("cnt_preload", instr_cnt, 16'hFFFF);
    start(16'h1205, 1'b0);
    cyc(4'd9, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check16("cnt_wrap", instr_cnt, 16'h0000);

    step();
    step();
    check16("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/proc_control.md
PROC_CONTROL -- requirements
Module: proc_control

Interface
REQ-001 Parameter: none; all encodings SHALL come from package proc_pkg.
REQ-002 clk  input  1  single system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 run  input  1  request to start one instruction; sampled only in state T0.
REQ-005 ir  input  16  instruction register contents: opcode ir[15:12], rX ir[11:9], rY ir[2:0], immediate ir[8:0] (mvi/addi/subi) or ir[7:0] (mvt).
REQ-006 ir_in  output  1  load-enable for the instruction register.
REQ-007 sel  output  4  bus mux select: 0-7 = R0-R7, 8 = G, 9 = D (zero-extended ir[8:0]), 10 = DT (ir[7:0] in the upper byte).
REQ-008 r_in  output  8  one-hot register write enables R0-R7.
REQ-009 a_in, g_in  output  1 each  load-enables for ALU operand register A and result register G.
REQ-010 addsub  output  1  ALU op, 0 = add, 1 = subtract.
REQ-011 done  output  1  one-cycle pulse on the last cycle of every instruction.
REQ-012 busy  output  1  high in any state other than T0.
REQ-013 illegal  output  1  one-cycle pulse, coincident with done, for undefined opcodes.
REQ-014 instr_cnt  output  16  count of completed instructions.

Function
REQ-015 FSM states SHALL be T0, T1, T2, T3; outputs are combinational from state and ir; unlisted outputs are 0 and sel = 0.
REQ-016 T0: ir_in = run; if run = 1, next state T1, otherwise stay in T0.
REQ-017 T1, opcode 0 (mv): sel = rY, r_in[rX] = 1, done = 1, next state T0.
REQ-018 T1, opcode 1 (mvi): sel = 9, r_in[rX] = 1, done = 1, next state T0.
REQ-019 T1, opcode 4 (mvt): sel = 10, r_in[rX] = 1, done = 1, next state T0.
REQ-020 T1, opcodes 2 (add), 3 (sub), 5 (addi), 6 (subi): sel = rX, a_in = 1, next state T2.
REQ-021 T2: sel = rY for add/sub or 9 for addi/subi; g_in = 1; addsub = 1 for sub/subi, 0 otherwise; next state T3.
REQ-022 T3: sel = 8, r_in[rX] = 1, done = 1, next state T0.
REQ-023 T1, opcodes 7-15: no enables, done = 1, illegal = 1, next state T0.
REQ-024 Latency: run accepted to done is 2 cycles for moves and illegal opcodes, 4 cycles for ALU ops.
REQ-025 run is ignored outside T0; a run held high SHALL start the next instruction in the cycle after done.
REQ-026 instr_cnt SHALL increment by 1 in the cycle after each done pulse (illegal included), wrapping from 0xFFFF to 0x0000.
REQ-027 rX = rY is legal; enables are as listed, with no special case.

Reset
REQ-028 While rst = 1, the FSM SHALL go to T0 on the next edge and instr_cnt SHALL clear to 0, overriding run and any in-flight instruction.
REQ-029 After reset with run = 0: ir_in = r_in = a_in = g_in = addsub = done = busy = illegal = 0, sel = 0, instr_cnt = 0.
REQ-030 Reset mid-instruction SHALL abort it with no done pulse and no count increment.

Structure
REQ-031 proc_pkg SHALL hold the sel codes (SEL_R0..SEL_R7 = 0..7, SEL_G = 8, SEL_D = 9, SEL_DT = 10), the opcode constants, and the state enum.
REQ-032 r_in generation SHALL use sub-module dec3to8 (3-bit input, enable, 8-bit one-hot output).

Verification
REQ-033 Apply rst, then hold run = 0 for 5 cycles -> all outputs 0, busy = 0, instr_cnt = 0.
REQ-034 ir = 0x1205 (mvi R1,#5), pulse run -> ir_in in T0; in T1 sel = 9, r_in = 0x02, done = 1; instr_cnt = 1.
REQ-035 ir = 0x2602 (add R3,R2) -> T1 sel = 3, a_in; T2 sel = 2, g_in, addsub = 0; T3 sel = 8, r_in = 0x08, done; total 4 cycles.
REQ-036 ir = 0x6A07 (subi R5,#7) -> T2 sel = 9, addsub = 1; T3 r_in = 0x20; ir = 0x4CAB (mvt R6) -> T1 sel = 10, r_in = 0x40.
REQ-037 ir = 0xF000 with run held high for 3 instructions -> illegal and done in each T1, no enables, back-to-back starts, instr_cnt = 3.
REQ-038 Assert rst in T2 of a sub -> next state T0, no done, instr_cnt unchanged; preload 0xFFFF then one done -> instr_cnt = 0x0000.
